// File: rtl/fetch_unit.sv
// Instruction fetch front-end: fetch PC, single-outstanding request/grant/response
// port to instruction memory, and a small {pc, instr} FIFO with valid/ready output.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        state, state_next;
    logic [31:0]   fpc;
    logic [31:0]   req_addr;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_after;
    logic          drop;
    logic          push, pop, load_req;

    assign imem_req  = (state == S_REQ);
    assign imem_addr = req_addr;
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;

    always_comb begin
        pop         = out_valid && out_ready;
        push        = (state == S_WAIT) && imem_rvalid && !drop && !redirect;
        count_after = count + CW'(push) - CW'(pop);
        load_req    = 1'b0;
        state_next  = state;
        case (state)
            S_IDLE: begin
                if (!redirect && (count < FULL)) begin
                    load_req   = 1'b1;
                    state_next = S_REQ;
                end
            end
            // Address is committed once presented; a redirect cannot retract it.
            S_REQ: begin
                if (imem_gnt) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (!redirect && (count_after < FULL)) begin
                        load_req   = 1'b1;
                        state_next = S_REQ;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop     <= 1'b0;
        end else if (redirect) begin
            fpc    <= redirect_pc & ~32'h3;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // A response arriving this same cycle is simply not pushed, so no drop needed.
            if (state == S_REQ || (state == S_WAIT && !imem_rvalid))
                drop <= 1'b1;
            else if (state == S_WAIT)
                drop <= 1'b0;
        end else begin
            if (load_req) begin
                req_addr <= fpc;
                fpc      <= fpc + 32'd4;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_after;
            if (state == S_WAIT && imem_rvalid) drop <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= req_addr;
            mem_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: zero-wait streaming, full FIFO,
// redirect corner cases and asynchronous reset mid-fetch.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks = 0;
    int failures = 0;

    logic        pend;
    logic [31:0] pend_addr;
    int          grants;
    logic [31:0] gnt_log [8];

    fetch_unit #(.RESET_PC(32'h0000_3000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock of a memory that grants immediately and responds on the next cycle.
    task automatic zw_cycle();
        logic        nreq;
        logic [31:0] naddr;
        imem_rvalid = pend;
        imem_rdata  = pend ? instr_of(pend_addr) : 32'h0;
        imem_gnt    = imem_req;
        nreq        = imem_req;
        naddr       = imem_addr;
        step();
        pend      = nreq;
        pend_addr = naddr;
        if (nreq) begin
            if (grants < 8) gnt_log[grants] = naddr;
            grants++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        pend = 1'b0; pend_addr = 32'h0; grants = 0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%h exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h3000) begin failures++; $display("FAIL rst_addr got=%h exp=00003000", imem_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", out_instr); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin failures++; $display("FAIL first_req got=%h/%h exp=1/00003000", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] seen_pc [3];
        logic [31:0] seen_in [3];
        int n = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 30 && n < 3; c++) begin
            if (out_valid && out_ready) begin
                seen_pc[n] = out_pc; seen_in[n] = out_instr; n++;
            end
            zw_cycle();
        end
        checks++; if (n != 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (seen_pc[i] !== 32'h3000 + 32'(4 * i)) begin
                failures++; $display("FAIL stream_pc%0d got=%h exp=%h", i, seen_pc[i], 32'h3000 + 32'(4 * i));
            end
            checks++;
            if (seen_in[i] !== instr_of(32'h3000 + 32'(4 * i))) begin
                failures++; $display("FAIL stream_instr%0d got=%h exp=%h", i, seen_in[i], instr_of(32'h3000 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 12; c++) zw_cycle();
        checks++; if (grants != 2) begin failures++; $display("FAIL full_grants got=%0d exp=2", grants); end
        checks++; if (gnt_log[0] !== 32'h3000 || gnt_log[1] !== 32'h3004) begin failures++; $display("FAIL full_addrs got=%h,%h exp=00003000,00003004", gnt_log[0], gnt_log[1]); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL full_req got=%h exp=0", imem_req); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin failures++; $display("FAIL full_head got=%h/%h exp=1/00003000", out_valid, out_pc); end
        out_ready = 1'b1;
        zw_cycle();
        out_ready = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL pop_req_early got=%h exp=0", imem_req); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3004) begin failures++; $display("FAIL pop_head got=%h/%h exp=1/00003004", out_valid, out_pc); end
        zw_cycle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin failures++; $display("FAIL resume_req got=%h/%h exp=1/00003008", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h3103;
        step();
        redirect = 1'b0;
        checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rdw_flush got=%h/%h exp=0/0", out_valid, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3100) begin failures++; $display("FAIL rdw_req got=%h/%h exp=1/00003100", imem_req, imem_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rdw_drop got=%h exp=0", out_valid); end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h3100);
        step();
        imem_rvalid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3100) begin failures++; $display("FAIL rdw_out got=%h/%h exp=1/00003100", out_valid, out_pc); end
        checks++; if (out_instr !== instr_of(32'h3100)) begin failures++; $display("FAIL rdw_instr got=%h exp=%h", out_instr, instr_of(32'h3100)); end
    endtask

    task automatic test_redirect_gnt();
        int  c;
        logic saw_bad = 1'b0;
        logic [31:0] first_pc = 32'h0;
        logic got = 1'b0;
        do_reset();
        out_ready = 1'b1;
        for (c = 0; c < 10; c++) begin
            if (imem_req && imem_addr == 32'h3004) break;
            zw_cycle();
        end
        checks++; if (c == 10) begin failures++; $display("FAIL rdg_timeout got=%h exp=00003004", imem_addr); end
        imem_gnt = 1'b1; imem_rvalid = 1'b0; redirect = 1'b1; redirect_pc = 32'h3200;
        step();
        imem_gnt = 1'b0; redirect = 1'b0;
        checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rdg_flush got=%h/%h exp=0/0", out_valid, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = instr_of(32'h3004);
        step();
        imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3200) begin failures++; $display("FAIL rdg_req got=%h/%h exp=1/00003200", imem_req, imem_addr); end
        pend = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid && out_pc == 32'h3004) saw_bad = 1'b1;
            if (out_valid && !got) begin first_pc = out_pc; got = 1'b1; end
            zw_cycle();
        end
        checks++; if (saw_bad) begin failures++; $display("FAIL rdg_stale got=00003004 exp=none"); end
        checks++; if (!got || first_pc !== 32'h3200) begin failures++; $display("FAIL rdg_first got=%h exp=00003200", first_pc); end
    endtask

    task automatic test_redirect_rvalid_pop();
        do_reset();
        for (int c = 0; c < 4; c++) zw_cycle();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000 || imem_req !== 1'b0) begin failures++; $display("FAIL rrp_pre got=%h/%h/%h exp=1/00003000/0", out_valid, out_pc, imem_req); end
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h3004);
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h3300;
        step();
        imem_rvalid = 1'b0; out_ready = 1'b0; redirect = 1'b0;
        checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rrp_flush got=%h/%h exp=0/0", out_valid, imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3300) begin failures++; $display("FAIL rrp_req got=%h/%h exp=1/00003300", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h3300);
        step();
        imem_rvalid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3300) begin failures++; $display("FAIL rrp_accept got=%h/%h exp=1/00003300", out_valid, out_pc); end
        checks++; if (out_instr !== instr_of(32'h3300)) begin failures++; $display("FAIL rrp_instr got=%h exp=%h", out_instr, instr_of(32'h3300)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] first_pc = 32'h0;
        logic got = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) zw_cycle();
        checks++; if (out_valid !== 1'b1 || imem_addr !== 32'h3004) begin failures++; $display("FAIL rm_pre got=%h/%h exp=1/00003004", out_valid, imem_addr); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin failures++; $display("FAIL rm_out got=%h/%h/%h exp=0/0/0", out_valid, out_pc, out_instr); end
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h3000) begin failures++; $display("FAIL rm_mem got=%h/%h exp=0/00003000", imem_req, imem_addr); end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; pend = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin failures++; $display("FAIL rm_restart got=%h/%h exp=1/00003000", imem_req, imem_addr); end
        out_ready = 1'b1;
        for (int k = 0; k < 10 && !got; k++) begin
            if (out_valid) begin first_pc = out_pc; got = 1'b1; end
            else zw_cycle();
        end
        checks++; if (!got || first_pc !== 32'h3000) begin failures++; $display("FAIL rm_first got=%h exp=00003000", first_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_gnt();
        test_redirect_rvalid_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
